uart_byte_tx: RTL

- Serial UART transmitter: accepts one byte over a valid/ready handshake and shifts it out on `uart_tx`.
- Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Contains its own baud-rate divider; no external bit-timing strobe.
- Sits between on-chip byte producers (command/echo logic) and the board RS232 TX pin. Counterpart of the existing UART receive path at the same baud and frame format.

---
 rtl/uart_byte_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: valid/ready byte input, start + 8 data (LSB first) + optional parity + 1/2 stop bits.
// Bit timing comes from an internal divider of CLK_FREQ/BAUD clocks per bit.
module uart_byte_tx #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BIT_CYC - 2);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             ODD_L     = (PARITY_ODD != 0);

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYC < 2) begin : g_bad_div
      $error("uart_byte_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_tx;
  logic             r_ready;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_par_nxt;
  logic             w_tx_nxt;
  logic             w_ready_nxt;
  logic             w_done_nxt;

  logic w_accept;
  logic w_bit_end;
  logic w_last_stop;

  assign w_accept    = tx_start && r_ready;
  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_last_stop = (r_bit == STOP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        // r_tx is loaded one cycle early with the bit the shifter will present next
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt = '0;
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        // Raise done/ready so they are visible during the final stop cycle itself
        if (w_last_stop && (r_cnt == CNT_PRE)) begin
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
        end
        if (w_bit_end) begin
          if (w_last_stop) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
      end
    endcase

    // Accept is possible from IDLE or the final stop cycle; it restarts the frame
    if (w_accept) begin
      w_state_nxt = S_START;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = tx_data;
      w_par_nxt   = (^tx_data) ^ ODD_L;
      w_tx_nxt    = 1'b0;
      w_ready_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign uart_tx  = r_tx;
  assign tx_ready = r_ready;
  assign tx_done  = r_done;

endmodule
